mem_req_rr_arbiter: RTL

Round-robin arbiter that shares one memory request port among `NREQ` requesters using valid/ready handshakes. It sits between the requestor-side request channels and the shared memory port. It forwards one beat per cycle through a registered output stage. Optionally, it holds the grant for the full length of a multi-beat burst.

---
 rtl/mem_req_rr_arbiter_if.sv | 54 +++++
 rtl/mem_req_rr_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_req_rr_arbiter_if.sv
// ============================================================================
//  Module   : mem_req_rr_arbiter_if
//  Brief    : Requester-side and memory-side handshake bundle for the
//             round-robin memory request arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_req_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   io_requestor_valid;
    logic [NREQ-1:0]   io_requestor_ready;
    logic [NREQ*W-1:0] io_requestor_bits;
    logic [NREQ-1:0]   io_requestor_last;
    logic              io_mem_valid;
    logic              io_mem_ready;
    logic [W-1:0]      io_mem_bits;
    logic [IDW-1:0]    io_mem_id;
    logic              io_mem_last;
    logic              io_busy;

    // Arbiter side: accepts requester beats and drives the shared memory port.
    modport master (
        input  io_requestor_valid,
        input  io_requestor_bits,
        input  io_requestor_last,
        input  io_mem_ready,
        output io_requestor_ready,
        output io_mem_valid,
        output io_mem_bits,
        output io_mem_id,
        output io_mem_last,
        output io_busy
    );

    // Environment side: requesters plus the memory that consumes beats.
    modport slave (
        output io_requestor_valid,
        output io_requestor_bits,
        output io_requestor_last,
        output io_mem_ready,
        input  io_requestor_ready,
        input  io_mem_valid,
        input  io_mem_bits,
        input  io_mem_id,
        input  io_mem_last,
        input  io_busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_req_rr_arbiter.sv
// ============================================================================
//  Module   : mem_req_rr_arbiter
//  Brief    : Round-robin arbiter sharing one memory request port among NREQ
//             valid/ready requesters through a registered output stage.
//             Optional burst lock: define ARB_LOCK_EN to hold the grant from
//             the first beat of a burst until its last beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    mem_req_rr_arbiter_if.master bus
);

    // Wrapping add used for both the search order and the pointer update.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned    off);
        int unsigned sum;
        sum = (32'(base) + off) % NREQ;
        return IDW'(sum);
    endfunction

    logic [IDW-1:0] r_ptr;
    logic           r_mem_valid;
    logic [W-1:0]   r_mem_bits;
    logic [IDW-1:0] r_mem_id;
    logic           r_mem_last;

    logic [IDW-1:0] w_rr_sel;
    logic           w_rr_found;
    logic [IDW-1:0] w_sel;
    logic           w_any_valid;
    logic           w_locked;
    logic           w_load_en;
    logic           w_xfer;
    logic           w_xfer_last;
    logic           w_ptr_adv;
    logic [NREQ-1:0] w_ready;

    // The output register can take a beat when it is empty or being drained.
    assign w_load_en = !r_mem_valid || bus.io_mem_ready;

    // First valid requester in the order ptr, ptr+1, ... (mod NREQ).
    always_comb begin
        w_rr_sel   = r_ptr;
        w_rr_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_rr_found && bus.io_requestor_valid[wrap_add(r_ptr, k)]) begin
                w_rr_sel   = wrap_add(r_ptr, k);
                w_rr_found = 1'b1;
            end
        end
    end

`ifdef ARB_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t    r_state;
    lock_state_t    w_state_nxt;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_owner_nxt;

    assign w_locked = (r_state == ST_LOCKED);

    // While locked only the burst owner may be granted; others see no ready.
    assign w_sel       = w_locked ? r_owner : w_rr_sel;
    assign w_any_valid = w_locked ? bus.io_requestor_valid[r_owner] : w_rr_found;

    // Lock state register; reset drops any burst in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Enter LOCKED on a non-final beat, leave on the owner's final beat.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !w_xfer_last) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_sel;
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_xfer_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Rotate priority only once a burst has completed.
    assign w_ptr_adv = w_xfer && w_xfer_last;
`else
    assign w_locked    = 1'b0;
    assign w_sel       = w_rr_sel;
    assign w_any_valid = w_rr_found;

    // Every beat is arbitrated on its own, so rotate after every transfer.
    assign w_ptr_adv = w_xfer;
`endif

    assign w_xfer      = w_load_en && w_any_valid;
    assign w_xfer_last = bus.io_requestor_last[w_sel];

    // One-hot ready toward the selected requester when a beat can be taken.
    always_comb begin
        w_ready = '0;
        if (w_load_en && w_any_valid) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    // Round-robin pointer: next search starts just past the last winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_ptr_adv) begin
            r_ptr <= wrap_add(w_sel, 1);
        end
    end

    // Output stage: load on transfer, drain when accepted with nothing new.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_valid <= 1'b0;
            r_mem_bits  <= '0;
            r_mem_id    <= '0;
            r_mem_last  <= 1'b0;
        end else if (w_load_en) begin
            r_mem_valid <= w_xfer;
            if (w_xfer) begin
                r_mem_bits <= bus.io_requestor_bits[32'(w_sel)*W +: W];
                r_mem_id   <= w_sel;
                r_mem_last <= w_xfer_last;
            end
        end
    end

    assign bus.io_requestor_ready = w_ready;
    assign bus.io_mem_valid       = r_mem_valid;
    assign bus.io_mem_bits        = r_mem_bits;
    assign bus.io_mem_id          = r_mem_id;
    assign bus.io_mem_last        = r_mem_last;
    assign bus.io_busy            = r_mem_valid | w_locked;

endmodule

`default_nettype wire
